imm_ext_pipe: RTL and testbench

Parametrised, flow-controlled immediate extender for the datapath's decode stage. Accepts an `IN_W`-bit immediate plus the instruction's 6-bit opcode, selects an extension mode (zero, sign, high-half, branch-offset), and delivers an `OUT_W`-bit operand through a 2-entry output buffer. A valid/ready handshake on both sides lets it sit between the fetch/decode register and the execute stage, absorbing one cycle of execute-side stall without dropping data.

---
 rtl/imm_ext_pkg.sv | 33 +++
 rtl/imm_ext_core.sv | 36 +++
 rtl/imm_ext_pipe.sv | 83 ++++++++
 tb/tb_imm_ext_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: extension modes, named opcodes
// and the opcode-to-mode decode.
package imm_ext_pkg;

   typedef enum logic [1:0] {
      MODE_ZERO   = 2'd0,
      MODE_SIGN   = 2'd1,
      MODE_HIGH   = 2'd2,
      MODE_BRANCH = 2'd3
   } mode_e;

   localparam logic [5:0] OP_ZEXT_A = 6'b110010;
   localparam logic [5:0] OP_ZEXT_B = 6'b110011;
   localparam logic [5:0] OP_SEXT   = 6'b111000;
   localparam logic [5:0] OP_HIGH   = 6'b111001;
   localparam logic [5:0] OP_BR_A   = 6'b111111;
   localparam logic [5:0] OP_BR_B   = 6'b000000;
   localparam logic [5:0] OP_BR_C   = 6'b000001;

   // Anything not explicitly listed is sign-extended.
   function automatic mode_e decode_mode(input logic [5:0] opcode);
      mode_e mode;
      case (opcode)
         OP_ZEXT_A, OP_ZEXT_B:     mode = MODE_ZERO;
         OP_HIGH:                  mode = MODE_HIGH;
         OP_BR_A, OP_BR_B, OP_BR_C: mode = MODE_BRANCH;
         OP_SEXT:                  mode = MODE_SIGN;
         default:                  mode = MODE_SIGN;
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: zero, sign, high-half placement and
// shifted sign-extended branch offset.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W     = 16,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned BR_SHIFT = 2
) (
   input  logic [IN_W-1:0]  In,
   input  mode_e            mode,
   output logic [OUT_W-1:0] Out
);

   localparam int unsigned PAD_W = OUT_W - IN_W;

   if (OUT_W <= IN_W || OUT_W < IN_W + BR_SHIFT) begin : g_bad_width
      $error("imm_ext_core: OUT_W must exceed IN_W and hold IN_W + BR_SHIFT bits");
   end

   logic [OUT_W-1:0] sign_ext;

   assign sign_ext = {{PAD_W{In[IN_W-1]}}, In};

   always_comb begin
      Out = '0;
      unique case (mode)
         MODE_ZERO:   Out = {{PAD_W{1'b0}}, In};
         MODE_SIGN:   Out = sign_ext;
         MODE_HIGH:   Out = {In, {PAD_W{1'b0}}};
         MODE_BRANCH: Out = sign_ext << BR_SHIFT;
         default:     Out = '0;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Flow-controlled immediate extender: decode + extend on the input side, then a
// 2-entry FIFO so one cycle of execute-side stall is absorbed without loss.
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W     = 16,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned BR_SHIFT = 2
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [IN_W-1:0]  In,
   input  logic [5:0]       Opcode,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [OUT_W-1:0] Out,
   output logic [1:0]       Out_mode
);

   mode_e            in_mode;
   logic [OUT_W-1:0] ext_val;

   assign in_mode = decode_mode(Opcode);

   imm_ext_core #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .BR_SHIFT (BR_SHIFT)
   ) u_core (
      .In   (In),
      .mode (in_mode),
      .Out  (ext_val)
   );

   logic [OUT_W-1:0] data_q [2];
   mode_e            mode_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       count_q, count_d;
   logic             push, pop;

   // Ready depends only on the occupancy register, never on Out_ready.
   assign In_ready  = (count_q != 2'd2);
   assign Out_valid = (count_q != 2'd0);
   assign push      = In_valid && In_ready;
   assign pop       = Out_valid && Out_ready;

   assign Out      = data_q[rd_ptr_q];
   assign Out_mode = mode_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         mode_q[0] <= MODE_ZERO;
         mode_q[1] <= MODE_ZERO;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= ext_val;
            mode_q[wr_ptr_q] <= in_mode;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: default-width instance plus an 8->16 variant.
module tb_imm_ext_pipe;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        In_valid = 1'b0;
   logic        In_ready;
   logic [15:0] In = '0;
   logic [5:0]  Opcode = '0;
   logic        Out_valid;
   logic        Out_ready = 1'b1;
   logic [31:0] Out;
   logic [1:0]  Out_mode;

   logic        in_valid2 = 1'b0;
   logic        in_ready2;
   logic [7:0]  in2 = '0;
   logic [5:0]  opcode2 = '0;
   logic        out_valid2;
   logic [15:0] out2;
   logic [1:0]  out_mode2;

   int n_chk = 0;
   int n_fail = 0;

   logic [33:0] sb[$];
   logic [17:0] sb2[$];
   logic [33:0] mon_e;
   logic [17:0] mon_e2;
   logic        stalled = 1'b0;
   logic [31:0] held_out;
   logic [1:0]  held_mode;

   always #5 Clk = ~Clk;

   imm_ext_pipe dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .In_valid  (In_valid),
      .In_ready  (In_ready),
      .In        (In),
      .Opcode    (Opcode),
      .Out_valid (Out_valid),
      .Out_ready (Out_ready),
      .Out       (Out),
      .Out_mode  (Out_mode)
   );

   imm_ext_pipe #(
      .IN_W     (8),
      .OUT_W    (16),
      .BR_SHIFT (2)
   ) dut2 (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .In_valid  (in_valid2),
      .In_ready  (in_ready2),
      .In        (in2),
      .Opcode    (opcode2),
      .Out_valid (out_valid2),
      .Out_ready (1'b1),
      .Out       (out2),
      .Out_mode  (out_mode2)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [33:0] model(input logic [15:0] d, input logic [5:0] op);
      logic [1:0]  m;
      logic [31:0] s, r;
      if (op == 6'b110010 || op == 6'b110011) m = 2'd0;
      else if (op == 6'b111001) m = 2'd2;
      else if (op == 6'b111111 || op == 6'b000000 || op == 6'b000001) m = 2'd3;
      else m = 2'd1;
      s = d[15] ? {16'hFFFF, d} : {16'h0000, d};
      case (m)
         2'd0:    r = {16'h0000, d};
         2'd1:    r = s;
         2'd2:    r = {d, 16'h0000};
         default: r = s * 32'd4;
      endcase
      return {m, r};
   endfunction

   // Output monitor, main instance: scoreboard pop and stall stability.
   always @(negedge Clk) begin
      if (!Reset_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_out", Out, held_out);
            check("stall_mode", {30'd0, Out_mode}, {30'd0, held_mode});
            check("stall_valid", {31'd0, Out_valid}, 32'd1);
         end
         if (Out_valid && Out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: got %h expected no output", Out);
            end else begin
               mon_e = sb.pop_front();
               check("sb_data", Out, mon_e[31:0]);
               check("sb_mode", {30'd0, Out_mode}, {30'd0, mon_e[33:32]});
            end
         end
         stalled   = Out_valid && !Out_ready;
         held_out  = Out;
         held_mode = Out_mode;
      end
   end

   // Output monitor, narrow instance (always ready).
   always @(negedge Clk) begin
      if (Reset_n && out_valid2) begin
         if (sb2.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb2_unexpected: got %h expected no output", out2);
         end else begin
            mon_e2 = sb2.pop_front();
            check("sb2_data", {16'd0, out2}, {16'd0, mon_e2[15:0]});
            check("sb2_mode", {30'd0, out_mode2}, {30'd0, mon_e2[17:16]});
         end
      end
   end

   task automatic send(input logic [15:0] din, input logic [5:0] op,
                       input logic [31:0] exp, input logic [1:0] m);
      int n = 0;
      In_valid = 1'b1;
      In       = din;
      Opcode   = op;
      @(negedge Clk);
      while (!In_ready && n < 50) begin
         n++;
         @(negedge Clk);
      end
      n_chk++;
      if (!In_ready) begin
         n_fail++;
         $display("FAIL send_timeout: In_ready got 0 expected 1");
      end else begin
         sb.push_back({m, exp});
      end
      @(posedge Clk);
      #1;
      In_valid = 1'b0;
   endtask

   task automatic send2(input logic [7:0] din, input logic [5:0] op,
                        input logic [15:0] exp, input logic [1:0] m);
      in_valid2 = 1'b1;
      in2       = din;
      opcode2   = op;
      @(negedge Clk);
      n_chk++;
      if (!in_ready2) begin
         n_fail++;
         $display("FAIL send2_ready: got 0 expected 1");
      end else begin
         sb2.push_back({m, exp});
      end
      @(posedge Clk);
      #1;
      in_valid2 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || sb2.size() != 0) && n < 100) begin
         n++;
         @(negedge Clk);
      end
      n_chk++;
      if (sb.size() != 0 || sb2.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", sb.size(), sb2.size());
      end
      @(posedge Clk);
      #1;
   endtask

   typedef struct {
      logic [15:0] din;
      logic [5:0]  op;
      logic [31:0] exp;
      logic [1:0]  m;
   } vec_t;

   vec_t sweep[6] = '{
      '{16'hFFFE, 6'b110010, 32'h0000FFFE, 2'd0},
      '{16'hFFFE, 6'b111000, 32'hFFFFFFFE, 2'd1},
      '{16'hFFFE, 6'b111001, 32'hFFFE0000, 2'd2},
      '{16'hFFFE, 6'b111111, 32'hFFFFFFF8, 2'd3},
      '{16'hFFFE, 6'b000011, 32'hFFFFFFFE, 2'd1},
      '{16'h1234, 6'b000000, 32'h000048D0, 2'd3}
   };

   logic [5:0] ops[8] = '{6'b110010, 6'b110011, 6'b111001, 6'b111111,
                          6'b000000, 6'b000001, 6'b111000, 6'b000011};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      check("rst_out_valid", {31'd0, Out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, In_ready}, 32'd1);
      check("rst_out", Out, 32'd0);
      check("rst_out_mode", {30'd0, Out_mode}, 32'd0);
      check("rst2_out", {16'd0, out2}, 32'd0);
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;

      // Mode sweep, one item per cycle, each visible one cycle after acceptance
      Out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send(sweep[i].din, sweep[i].op, sweep[i].exp, sweep[i].m);
         check("lat_valid", {31'd0, Out_valid}, 32'd1);
         check("lat_out", Out, sweep[i].exp);
      end
      drain();

      // Backpressure: two absorbed, third held
      Out_ready = 1'b0;
      send(16'h0001, 6'b111000, 32'h00000001, 2'd1);
      check("bp_ready_after1", {31'd0, In_ready}, 32'd1);
      send(16'h0002, 6'b111000, 32'h00000002, 2'd1);
      check("bp_ready_after2", {31'd0, In_ready}, 32'd0);
      In_valid = 1'b1;
      In       = 16'h0003;
      Opcode   = 6'b111000;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("bp_held", {31'd0, In_ready}, 32'd0);
      end
      @(posedge Clk);
      #1;
      Out_ready = 1'b1;
      check("bp_ready_before_pop", {31'd0, In_ready}, 32'd0);
      @(posedge Clk);
      #1;
      check("bp_ready_after_pop", {31'd0, In_ready}, 32'd1);
      send(16'h0003, 6'b111000, 32'h00000003, 2'd1);
      drain();

      // Simultaneous push and pop at count 1
      Out_ready = 1'b0;
      send(16'h8000, 6'b111000, 32'hFFFF8000, 2'd1);
      Out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(16'h0100 + 16'(i), 6'b111000, 32'h00000100 + 32'(i), 2'd1);
         check("pp_valid", {31'd0, Out_valid}, 32'd1);
         check("pp_ready", {31'd0, In_ready}, 32'd1);
      end
      drain();

      // Reset with two entries buffered
      Out_ready = 1'b0;
      send(16'h0011, 6'b110010, 32'h00000011, 2'd0);
      send(16'h0022, 6'b111001, 32'h00220000, 2'd2);
      @(negedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, Out_valid}, 32'd0);
      check("mid_rst_out", Out, 32'd0);
      check("mid_rst_mode", {30'd0, Out_mode}, 32'd0);
      check("mid_rst_ready", {31'd0, In_ready}, 32'd1);
      sb.delete();
      @(negedge Clk);
      @(posedge Clk);
      #1;
      Reset_n   = 1'b1;
      Out_ready = 1'b1;
      send(16'h00FF, 6'b110010, 32'h000000FF, 2'd0);
      check("post_rst_out", Out, 32'h000000FF);
      drain();

      // Narrow parameter variant
      send2(8'h80, 6'b111000, 16'hFF80, 2'd1);
      send2(8'h80, 6'b110010, 16'h0080, 2'd0);
      send2(8'h80, 6'b111001, 16'h8000, 2'd2);
      send2(8'h80, 6'b000001, 16'hFE00, 2'd3);
      drain();

      // Random stress against the reference model
      for (int c = 0; c < 10000; c++) begin
         In_valid  = 1'($urandom_range(0, 1));
         In        = 16'($urandom);
         Opcode    = ($urandom_range(0, 11) < 8) ? ops[$urandom_range(0, 7)]
                                                : 6'($urandom);
         Out_ready = ($urandom_range(0, 3) != 0);
         @(negedge Clk);
         if (In_valid && In_ready) sb.push_back(model(In, Opcode));
         @(posedge Clk);
         #1;
      end
      In_valid  = 1'b0;
      Out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
